// File: rtl/data_mem_unit_if.sv
// Bus between the core datapath and data_mem_unit.
//   master : core side, drives the request, store data, PC and write-back select.
//   slave  : data_mem_unit side, returns RESULT and the READY/BUSY/FAULT status.
// Signals:
//   REQ        access request, sampled only while the unit is idle
//   WE         1 = store, 0 = load
//   FUNCT3     access size/type (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   ADDR       byte address, also the ALU-result write-back source
//   WDATA      store data, low bytes used for B/H
//   PC         current PC, used for PC+4
//   RESULT_SRC write-back select
//   RESULT     write-back value
//   READY      one-cycle completion pulse
//   BUSY       high whenever the unit is not idle
//   FAULT      valid with READY, 1 = misaligned or illegal access
interface data_mem_unit_if;
  logic        REQ;
  logic        WE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] PC;
  logic [1:0]  RESULT_SRC;
  logic [31:0] RESULT;
  logic        READY;
  logic        BUSY;
  logic        FAULT;

  modport master (
    output REQ, WE, FUNCT3, ADDR, WDATA, PC, RESULT_SRC,
    input  RESULT, READY, BUSY, FAULT
  );

  modport slave (
    input  REQ, WE, FUNCT3, ADDR, WDATA, PC, RESULT_SRC,
    output RESULT, READY, BUSY, FAULT
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data-memory unit for the RISC-V datapath.
// Byte/halfword/word loads and stores with RV32I sign/zero extension, WAIT_CYC wait
// states ahead of the array access, REQ/READY handshake, misaligned/illegal detection,
// and the write-back result mux (ALU result / load data / PC+4).
// Ports:
//   CLK  clock, rising edge
//   RST  asynchronous active-low reset; clears state, load register and the whole array
//   bus  data_mem_unit_if.slave (request, store data, PC, RESULT_SRC in;
//        RESULT, READY, BUSY, FAULT out)
module data_mem_unit #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned WAIT_CYC   = 1
) (
  input  logic           CLK,
  input  logic           RST,
  data_mem_unit_if.slave bus
);

  localparam int unsigned Depth    = 1 << DEPTH_LOG2;
  localparam int unsigned AddrW    = DEPTH_LOG2 + 2;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYC);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              capture;

  // Request captured at acceptance; frozen until the next acceptance.
  logic              we_q;
  logic [2:0]        f3_q;
  logic [AddrW-1:0]  addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       ld_q, ld_d;
  logic [31:0]       mem_q [Depth];

  logic              legal_load, legal_store, misaligned, req_fault;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]        byte_en;
  logic [31:0]       wlanes;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_ext;

  // Request decode, evaluated on the live inputs while idle.
  always_comb begin
    legal_load  = 1'b0;
    legal_store = 1'b0;
    case (bus.FUNCT3)
      3'b000, 3'b001, 3'b010: begin
        legal_load  = 1'b1;
        legal_store = 1'b1;
      end
      3'b100, 3'b101: legal_load = 1'b1;
      default: ;
    endcase
    misaligned = ((bus.FUNCT3[1:0] == 2'b01) && bus.ADDR[0]) ||
                 ((bus.FUNCT3[1:0] == 2'b10) && (bus.ADDR[1:0] != 2'b00));
    req_fault  = (bus.WE ? !legal_store : !legal_load) || misaligned;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.REQ) begin
          capture = 1'b1;
          fault_d = req_fault;
          if (req_fault) begin
            state_d = StResp;
          end else if (WAIT_CYC == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        // <= also catches a zero count so the FSM can never stall here
        if (cnt_q <= 4'd1) state_d = StAccess;
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= bus.WE;
      f3_q    <= bus.FUNCT3;
      addr_q  <= bus.ADDR[AddrW-1:0];
      wdata_q <= bus.WDATA;
    end
  end

  // Lane selection for stores and lane extraction for loads. Upper address bits
  // were dropped at capture, so the array wraps modulo its depth.
  always_comb begin
    word_idx = addr_q[AddrW-1:2];
    unique case (f3_q[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wlanes  = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wlanes  = wdata_q;
      end
    endcase

    rd_shift = mem_q[word_idx] >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'd0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase

    ld_d = ld_q;
    if (state_q == StAccess && !we_q) ld_d = ld_ext;
  end

  // Faulted accesses bypass StAccess, so they can never write or load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (state_q == StAccess && we_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ld_q <= '0;
    else      ld_q <= ld_d;
  end

  assign bus.READY = (state_q == StResp);
  assign bus.BUSY  = (state_q != StIdle);
  assign bus.FAULT = (state_q == StResp) && fault_q;

  always_comb begin
    unique case (bus.RESULT_SRC)
      2'b01:   bus.RESULT = ld_q;
      2'b10:   bus.RESULT = bus.PC + 32'd4;
      default: bus.RESULT = bus.ADDR;
    endcase
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: one instance with WAIT_CYC=1 and one with WAIT_CYC=3.
// Expected latency/fault/load-register values are queued when a request is driven
// and popped when READY is seen.
module tb_data_mem_unit;

  localparam int W1 = 1;
  localparam int W3 = 3;

  logic CLK;
  logic RST;

  data_mem_unit_if bus1 ();
  data_mem_unit_if bus3 ();

  data_mem_unit #(.DEPTH_LOG2(8), .WAIT_CYC(W1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  data_mem_unit #(.DEPTH_LOG2(8), .WAIT_CYC(W3)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        fault;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_ld1 = 32'd0;
  logic [31:0] exp_ld3 = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (which == 1) begin
      bus1.REQ = req; bus1.WE = we; bus1.FUNCT3 = f3; bus1.ADDR = addr; bus1.WDATA = wdata;
    end else begin
      bus3.REQ = req; bus3.WE = we; bus3.FUNCT3 = f3; bus3.ADDR = addr; bus3.WDATA = wdata;
    end
  endtask

  function automatic logic rdy(input int which);
    return (which == 1) ? bus1.READY : bus3.READY;
  endfunction

  function automatic logic flt(input int which);
    return (which == 1) ? bus1.FAULT : bus3.FAULT;
  endfunction

  function automatic logic [31:0] res(input int which);
    return (which == 1) ? bus1.RESULT : bus3.RESULT;
  endfunction

  // One access. Latency counts the accepting edge as edge 1.
  task automatic access(input int which, input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_fault, input logic [31:0] load_val);
    exp_t e;
    int   edges;
    if (!exp_fault && !we) begin
      if (which == 1) exp_ld1 = load_val;
      else            exp_ld3 = load_val;
    end
    e.fault = exp_fault;
    e.data  = (which == 1) ? exp_ld1 : exp_ld3;
    e.lat   = exp_fault ? 1 : ((which == 1) ? W1 : W3) + 2;
    sb_q.push_back(e);

    @(negedge CLK);
    drive(which, 1'b1, we, f3, addr, wdata);
    @(posedge CLK);
    #1;
    if (which == 1) bus1.REQ = 1'b0;
    else            bus3.REQ = 1'b0;
    edges = 1;
    while (!rdy(which) && edges < 40) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    e = sb_q.pop_front();
    check({tag, " latency"}, 32'(edges), 32'(e.lat));
    check({tag, " fault"}, {31'd0, flt(which)}, {31'd0, e.fault});
    check({tag, " result"}, res(which), e.data);
    @(posedge CLK);
    #1;
    check({tag, " ready pulse"}, {31'd0, rdy(which)}, 32'd0);
  endtask

  int busy_n;
  int rdy_n;

  initial begin
    RST = 1'b0;
    drive(1, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    drive(3, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0);
    bus1.PC = 32'd0; bus1.RESULT_SRC = 2'b01;
    bus3.PC = 32'd0; bus3.RESULT_SRC = 2'b01;
    #12;
    check("rst ready", {31'd0, bus1.READY}, 32'd0);
    check("rst busy",  {31'd0, bus1.BUSY},  32'd0);
    check("rst fault", {31'd0, bus1.FAULT}, 32'd0);
    check("rst ldreg", bus1.RESULT, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Word store/load
    access(1, "sw 10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    access(1, "lw 10",  1'b0, 3'b010, 32'h10, 32'd0,        1'b0, 32'hDEADBEEF);
    // Byte lanes and extension
    access(1, "sw 10b", 1'b1, 3'b010, 32'h10, 32'h80C0FFEE, 1'b0, 32'd0);
    access(1, "sb 11",  1'b1, 3'b000, 32'h11, 32'h1234567F, 1'b0, 32'd0);
    access(1, "lb 11",  1'b0, 3'b000, 32'h11, 32'd0,        1'b0, 32'h0000007F);
    access(1, "lbu 12", 1'b0, 3'b100, 32'h12, 32'd0,        1'b0, 32'h000000C0);
    access(1, "lb 12",  1'b0, 3'b000, 32'h12, 32'd0,        1'b0, 32'hFFFFFFC0);
    access(1, "lw 10c", 1'b0, 3'b010, 32'h10, 32'd0,        1'b0, 32'h80C07FEE);
    // Halfword lanes and extension
    access(1, "sh 12",  1'b1, 3'b001, 32'h12, 32'h00AB8001, 1'b0, 32'd0);
    access(1, "lh 12",  1'b0, 3'b001, 32'h12, 32'd0,        1'b0, 32'hFFFF8001);
    access(1, "lhu 12", 1'b0, 3'b101, 32'h12, 32'd0,        1'b0, 32'h00008001);
    access(1, "lw 10d", 1'b0, 3'b010, 32'h10, 32'd0,        1'b0, 32'h80017FEE);
    // Faults: memory and load register untouched
    access(1, "sw 20",  1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0, 32'd0);
    access(1, "lh 13",  1'b0, 3'b001, 32'h13, 32'd0,        1'b1, 32'd0);
    access(1, "sw 22",  1'b1, 3'b010, 32'h22, 32'hAAAAAAAA, 1'b1, 32'd0);
    access(1, "lw 20",  1'b0, 3'b010, 32'h20, 32'd0,        1'b0, 32'h11223344);
    access(1, "ld f3=011", 1'b0, 3'b011, 32'h20, 32'd0,     1'b1, 32'd0);
    access(1, "st f3=100", 1'b1, 3'b100, 32'h20, 32'hBBBBBBBB, 1'b1, 32'd0);
    access(1, "sh 21",  1'b1, 3'b001, 32'h21, 32'hCCCCCCCC, 1'b1, 32'd0);
    access(1, "lw 20b", 1'b0, 3'b010, 32'h20, 32'd0,        1'b0, 32'h11223344);
    // Address wrap: 0x420 aliases 0x20 in a 256-word array
    access(1, "sw 420", 1'b1, 3'b010, 32'h420, 32'h5A5A5A5A, 1'b0, 32'd0);
    access(1, "lw 20c", 1'b0, 3'b010, 32'h20, 32'd0,        1'b0, 32'h5A5A5A5A);

    // Write-back mux
    @(negedge CLK);
    bus1.RESULT_SRC = 2'b10; bus1.PC = 32'hFFFFFFFC;
    #1 check("pc+4 wrap", bus1.RESULT, 32'h00000000);
    bus1.PC = 32'h00000100;
    #1 check("pc+4", bus1.RESULT, 32'h00000104);
    bus1.RESULT_SRC = 2'b11; bus1.ADDR = 32'h1234;
    #1 check("src 11", bus1.RESULT, 32'h00001234);
    bus1.RESULT_SRC = 2'b00; bus1.ADDR = 32'hABCD;
    #1 check("src 00", bus1.RESULT, 32'h0000ABCD);
    bus1.RESULT_SRC = 2'b01;
    #1 check("src 01", bus1.RESULT, 32'h5A5A5A5A);

    // WAIT_CYC=3: REQ held during the access is ignored, inputs are frozen
    access(3, "sw3 8",  1'b1, 3'b010, 32'h8, 32'hCAFEF00D, 1'b0, 32'd0);
    @(negedge CLK);
    drive(3, 1'b1, 1'b0, 3'b010, 32'h8, 32'd0);
    busy_n = 0;
    rdy_n  = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      #1;
      busy_n += int'(bus3.BUSY);
      rdy_n  += int'(bus3.READY);
      if (i >= 4) begin
        bus3.REQ = 1'b0;
      end else begin
        bus3.ADDR = 32'h0; bus3.WE = 1'b1; bus3.WDATA = 32'hFFFFFFFF; bus3.FUNCT3 = 3'b000;
      end
    end
    exp_ld3 = 32'hCAFEF00D;
    check("held req busy cycles", 32'(busy_n), 32'd5);
    check("held req ready pulses", 32'(rdy_n), 32'd1);
    check("held req load", bus3.RESULT, exp_ld3);
    access(3, "lw3 8",  1'b0, 3'b010, 32'h8, 32'd0,        1'b0, 32'hCAFEF00D);
    access(3, "lw3 0",  1'b0, 3'b010, 32'h0, 32'd0,        1'b0, 32'h00000000);

    // Reset during WAIT of a store aborts it
    @(negedge CLK);
    drive(1, 1'b1, 1'b1, 3'b010, 32'h40, 32'h55AA55AA);
    @(posedge CLK);
    #1;
    bus1.REQ = 1'b0;
    check("busy in wait", {31'd0, bus1.BUSY}, 32'd1);
    #2 RST = 1'b0;
    #1;
    check("mid rst ready", {31'd0, bus1.READY}, 32'd0);
    check("mid rst busy",  {31'd0, bus1.BUSY},  32'd0);
    check("mid rst fault", {31'd0, bus1.FAULT}, 32'd0);
    check("mid rst ldreg", bus1.RESULT, 32'd0);
    exp_ld1 = 32'd0;
    exp_ld3 = 32'd0;
    @(negedge CLK);
    RST = 1'b1;
    access(1, "lw 40 after rst", 1'b0, 3'b010, 32'h40, 32'd0, 1'b0, 32'd0);
    access(1, "lw 10 after rst", 1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 32'd0);
    access(3, "lw3 8 after rst", 1'b0, 3'b010, 32'h8,  32'd0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
